// File: rtl/timer_sched_pkg.sv
// Shared encodings for the timer interval scheduler: FSM states, CPU/timer register map,
// timer control words and the minimum programmable interval.
package timer_sched_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StStop = 3'd1,
    StLoad = 3'd2,
    StArm  = 3'd3,
    StWait = 3'd4,
    StDone = 3'd5,
    StHalt = 3'd6
  } state_e;

  localparam logic [1:0] CpuCtrl = 2'd0;
  localparam logic [1:0] CpuFifo = 2'd1;
  localparam logic [1:0] CpuCnt  = 2'd2;
  localparam logic [1:0] CpuStat = 2'd3;

  localparam int unsigned CtrlRun   = 0;
  localparam int unsigned CtrlLoop  = 1;
  localparam int unsigned CtrlIe    = 2;
  localparam int unsigned CtrlFlush = 3;

  localparam logic [1:0] TmrCtrl   = 2'd0;
  localparam logic [1:0] TmrPreset = 2'd1;

  localparam logic [31:0] TMR_CTRL_ARM = 32'h9;  // one-shot, irq enabled, running
  localparam logic [31:0] TMR_CTRL_OFF = 32'h0;

  localparam logic [31:0] ClampMin = 32'd2;

  // Presets of 0 or 1 would never produce a usable one-shot interrupt.
  function automatic logic [31:0] clamp_interval(logic [31:0] v);
    return (v < ClampMin) ? ClampMin : v;
  endfunction

endpackage

// File: rtl/interval_fifo.sv
// DEPTH x 32 synchronous FIFO with push, pop, flush and a rotate (pop head, re-push at tail)
// operation; a push may accompany a pop or a rotate in the same cycle.
module interval_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [31:0]   data_i,
  input  logic          pop_i,
  input  logic          rotate_i,
  output logic [31:0]   head_o,
  output logic [LW-1:0] level_o,
  output logic [LW-1:0] level_next_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          drop_o
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_pop, do_rot, accept;

  always_comb begin
    empty_o = (level_q == '0);
    full_o  = (level_q == LW'(DEPTH));
    do_pop  = pop_i & ~empty_o;
    do_rot  = rotate_i & ~empty_o;
    // A plain pop frees a slot this cycle; a rotate refills the slot it frees.
    accept  = push_i & (~full_o | do_pop);
    drop_o  = push_i & ~accept;
    rptr_d  = rptr_q + AW'(do_pop | do_rot);
    wptr_d  = wptr_q + AW'(do_rot) + AW'(accept);
    level_d = level_q + LW'(accept) - LW'(do_pop);
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      level_d = '0;
    end
    level_o      = level_q;
    level_next_o = level_d;
    head_o       = empty_o ? 32'd0 : mem_q[rptr_q];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      level_q <= level_d;
      if (!flush_i) begin
        if (do_rot) mem_q[wptr_q] <= mem_q[rptr_q];
        if (accept) mem_q[wptr_q + AW'(do_rot)] <= data_i;
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Interval scheduler: sole bus master of one countdown timer, programs queued intervals one
// after another and counts completions, with a CPU register window and interrupt.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [3:2]  ADD_I,
  input  logic        WE_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        IRQ,
  output logic [3:2]  TADD_O,
  output logic        TWE_O,
  output logic [31:0] TDAT_O,
  input  logic [31:0] TDAT_I,
  input  logic        TIRQ_I
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  state_e          state_q, state_d;
  logic            blank_q;
  logic            run_q, run_d, loop_q, loop_d, ie_q, ie_d;
  logic            pending_q, pending_d, ovf_q, ovf_d;
  logic [CNTW-1:0] done_cnt_q, done_cnt_d;

  logic            wr_ctrl, wr_fifo, wr_cnt, flush, in_done;
  logic [31:0]     fifo_head;
  logic [LW-1:0]   fifo_level, fifo_level_next;
  logic            fifo_full, fifo_empty, fifo_drop;
  logic            unused_tdat;

  assign unused_tdat = ^TDAT_I;

  assign wr_ctrl = WE_I & (ADD_I == CpuCtrl);
  assign wr_fifo = WE_I & (ADD_I == CpuFifo);
  assign wr_cnt  = WE_I & (ADD_I == CpuCnt);
  assign flush   = wr_ctrl & DAT_I[CtrlFlush];
  assign in_done = (state_q == StDone);

  interval_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (CLK_I),
    .rst_i        (RST_I),
    .flush_i      (flush),
    .push_i       (wr_fifo),
    .data_i       (clamp_interval(DAT_I)),
    .pop_i        (in_done & ~loop_q),
    .rotate_i     (in_done & loop_q),
    .head_o       (fifo_head),
    .level_o      (fifo_level),
    .level_next_o (fifo_level_next),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .drop_o       (fifo_drop)
  );

  always_comb begin
    state_d = state_q;
    TWE_O   = 1'b0;
    TADD_O  = 2'd0;
    TDAT_O  = 32'd0;
    case (state_q)
      StIdle: if (run_q && !fifo_empty && !flush) state_d = StStop;
      StStop: begin
        TWE_O   = 1'b1;
        TADD_O  = TmrCtrl;
        TDAT_O  = TMR_CTRL_OFF;
        state_d = flush ? StHalt : StLoad;
      end
      StLoad: begin
        TWE_O   = 1'b1;
        TADD_O  = TmrPreset;
        TDAT_O  = fifo_head;
        state_d = flush ? StHalt : StArm;
      end
      StArm: begin
        TWE_O   = 1'b1;
        TADD_O  = TmrCtrl;
        TDAT_O  = TMR_CTRL_ARM;
        state_d = flush ? StHalt : StWait;
      end
      // The first WAIT cycle may still see the previous interval's level interrupt.
      StWait: begin
        if (flush) state_d = StHalt;
        else if (TIRQ_I && !blank_q) state_d = StDone;
      end
      StDone: state_d = (run_q && fifo_level_next != '0) ? StStop : StIdle;
      StHalt: begin
        TWE_O   = 1'b1;
        TADD_O  = TmrCtrl;
        TDAT_O  = TMR_CTRL_OFF;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    run_d      = wr_ctrl ? DAT_I[CtrlRun] : run_q;
    loop_d     = wr_ctrl ? DAT_I[CtrlLoop] : loop_q;
    ie_d       = wr_ctrl ? DAT_I[CtrlIe] : ie_q;
    ovf_d      = flush ? 1'b0 : (ovf_q | fifo_drop);
    pending_d  = pending_q;
    done_cnt_d = done_cnt_q;
    // A completion coinciding with a counter clear is kept as the first new completion.
    if (in_done) begin
      pending_d  = 1'b1;
      done_cnt_d = wr_cnt ? CNTW'(1) : done_cnt_q + CNTW'(1);
    end else if (wr_cnt) begin
      pending_d  = 1'b0;
      done_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= StIdle;
      blank_q    <= 1'b0;
      run_q      <= 1'b0;
      loop_q     <= 1'b0;
      ie_q       <= 1'b0;
      pending_q  <= 1'b0;
      ovf_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      blank_q    <= (state_q == StArm);
      run_q      <= run_d;
      loop_q     <= loop_d;
      ie_q       <= ie_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  always_comb begin
    DAT_O = 32'd0;
    case (ADD_I)
      CpuCtrl: DAT_O = {29'd0, ie_q, loop_q, run_q};
      CpuFifo: DAT_O = fifo_head;
      CpuCnt:  DAT_O = 32'(done_cnt_q);
      CpuStat: DAT_O = {21'd0, state_q, 4'(fifo_level), ovf_q, fifo_full, fifo_empty, pending_q};
      default: DAT_O = 32'd0;
    endcase
  end

  assign IRQ = ie_q & pending_q;

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched: queue-based reference model compared every cycle,
// a behavioural one-shot timer answering the DUT, directed scenarios then random traffic.
module tb_timer_sched;
  import timer_sched_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = 16;

  logic        CLK_I = 1'b0;
  logic        RST_I, WE_I, TIRQ_I;
  logic [1:0]  ADD_I;
  logic [31:0] DAT_I, TDAT_I;
  logic [31:0] DAT_O, TDAT_O;
  logic [1:0]  TADD_O;
  logic        IRQ, TWE_O;

  timer_sched #(
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) dut (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .ADD_I  (ADD_I),
    .WE_I   (WE_I),
    .DAT_I  (DAT_I),
    .DAT_O  (DAT_O),
    .IRQ    (IRQ),
    .TADD_O (TADD_O),
    .TWE_O  (TWE_O),
    .TDAT_O (TDAT_O),
    .TDAT_I (TDAT_I),
    .TIRQ_I (TIRQ_I)
  );

  always #10 CLK_I = ~CLK_I;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: scheduler state as a queue of intervals plus a few flags.
  logic [31:0]     q[$];
  state_e          m_st = StIdle;
  int              m_age = 0;
  logic            m_run = 0, m_loop = 0, m_ie = 0, m_pend = 0, m_ovf = 0;
  logic [CNTW-1:0] m_cnt = '0;
  bit              armed = 0;

  task automatic model_step();
    logic        fl, push, clr, orun, oloop;
    logic [31:0] v;
    int          osz;
    state_e      nst;
    if (RST_I) begin
      q.delete();
      m_st = StIdle; m_age = 0; m_run = 0; m_loop = 0; m_ie = 0;
      m_pend = 0; m_ovf = 0; m_cnt = '0; armed = 1;
      return;
    end
    osz   = q.size();
    orun  = m_run;
    oloop = m_loop;
    fl    = WE_I && ADD_I == 2'd0 && DAT_I[3];
    push  = WE_I && ADD_I == 2'd1;
    clr   = WE_I && ADD_I == 2'd2;
    if (m_st == StDone && q.size() > 0) begin
      v = q.pop_front();
      if (oloop) q.push_back(v);
    end
    if (push) begin
      if (q.size() < DEPTH) q.push_back(DAT_I < 2 ? 32'd2 : DAT_I);
      else m_ovf = 1;
    end
    if (fl) begin
      q.delete();
      m_ovf = 0;
    end
    if (WE_I && ADD_I == 2'd0) begin
      m_run = DAT_I[0]; m_loop = DAT_I[1]; m_ie = DAT_I[2];
    end
    if (m_st == StDone) begin
      m_cnt  = clr ? CNTW'(1) : m_cnt + CNTW'(1);
      m_pend = 1;
    end else if (clr) begin
      m_cnt  = '0;
      m_pend = 0;
    end
    nst = m_st;
    case (m_st)
      StIdle: if (orun && osz > 0 && !fl) nst = StStop;
      StStop: nst = fl ? StHalt : StLoad;
      StLoad: nst = fl ? StHalt : StArm;
      StArm: begin nst = fl ? StHalt : StWait; m_age = 0; end
      StWait: begin
        if (fl) nst = StHalt;
        else if (TIRQ_I && m_age > 0) nst = StDone;
        else m_age++;
      end
      StDone: nst = (orun && q.size() > 0) ? StStop : StIdle;
      default: nst = StIdle;
    endcase
    m_st = nst;
  endtask

  task automatic compare();
    logic [31:0] head, e_dat, e_tdat;
    int          sz;
    logic        e_twe;
    sz     = q.size();
    head   = (sz > 0) ? q[0] : 32'd0;
    e_twe  = (m_st == StStop || m_st == StLoad || m_st == StArm || m_st == StHalt);
    e_tdat = (m_st == StLoad) ? head : (m_st == StArm) ? 32'h9 : 32'd0;
    case (ADD_I)
      2'd0: e_dat = {29'd0, m_ie, m_loop, m_run};
      2'd1: e_dat = head;
      2'd2: e_dat = 32'(m_cnt);
      default: e_dat = {21'd0, m_st, 4'(sz), m_ovf, sz == DEPTH, sz == 0, m_pend};
    endcase
    check("twe", TWE_O, e_twe);
    check("tadd", TADD_O, (m_st == StLoad) ? 32'd1 : 32'd0);
    check("tdat", TDAT_O, e_tdat);
    check("irq", IRQ, m_ie & m_pend);
    check("dat_o", DAT_O, e_dat);
  endtask

  initial forever begin
    @(posedge CLK_I);
    model_step();
  end

  initial forever begin
    @(negedge CLK_I);
    if (armed) compare();
  end

  // Behavioural one-shot timer: level interrupt some cycles after arming, cleared on disable.
  logic [31:0] t_pre = 0;
  int          t_cnt = 0;
  logic        t_en = 0, t_irq = 0;

  initial forever begin
    @(negedge CLK_I);
    if (RST_I) begin
      t_pre = 0; t_en = 0; t_irq = 0;
    end else if (TWE_O) begin
      if (TADD_O == 2'd1) t_pre = TDAT_O;
      else if (TADD_O == 2'd0) begin
        if (TDAT_O[0]) begin
          t_en  = 1;
          t_cnt = (t_pre > 15) ? 15 : int'(t_pre);
        end else begin
          t_en  = 0;
          t_irq = 0;
        end
      end
    end else if (t_en && !t_irq) begin
      if (t_cnt <= 1) t_irq = 1;
      else t_cnt--;
    end
  end

  bit noise_en = 0;

  task automatic tick();
    @(posedge CLK_I);
    #1;
    TIRQ_I = t_irq | (noise_en && $urandom_range(0, 7) == 0);
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    WE_I = 1; ADD_I = a; DAT_I = d;
    tick();
    WE_I = 0;
  endtask

  task automatic rd(logic [1:0] a, logic [31:0] exp, string name);
    ADD_I = a;
    #1;
    check(name, DAT_O, exp);
  endtask

  initial begin
    RST_I = 1; WE_I = 0; ADD_I = 0; DAT_I = 0; TIRQ_I = 0; TDAT_I = 32'hA5A5_0000;
    repeat (2) tick();
    RST_I = 0;
    check("rst_twe", TWE_O, 0);
    check("rst_tdat", TDAT_O, 0);
    check("rst_irq", IRQ, 0);
    rd(2'd0, 32'd0, "rst_w0");
    rd(2'd1, 32'd0, "rst_w1");
    rd(2'd2, 32'd0, "rst_w2");
    rd(2'd3, 32'h2, "rst_w3");

    // Single interval: ctrl off, preset, arm, then one completion.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'd5);
    tick();
    check("t1_stop_twe", TWE_O, 1);
    check("t1_stop_dat", TDAT_O, 0);
    tick();
    check("t1_load_adr", TADD_O, 1);
    check("t1_load_dat", TDAT_O, 10);
    tick();
    check("t1_arm_dat", TDAT_O, 32'h9);
    for (int i = 0; i < 60 && !IRQ; i++) tick();
    check("t1_irq", IRQ, 1);
    rd(2'd2, 32'd1, "t1_cnt");
    wr(2'd2, 32'd0);
    check("t1_irq_clr", IRQ, 0);

    // Overflow, then drain four intervals.
    wr(2'd0, 32'd4);
    wr(2'd1, 32'd5); wr(2'd1, 32'd7); wr(2'd1, 32'd9); wr(2'd1, 32'd11); wr(2'd1, 32'd13);
    rd(2'd3, 32'h4C, "t2_status");
    rd(2'd1, 32'd5, "t2_head");
    wr(2'd0, 32'd5);
    for (int i = 0; i < 400; i++) begin
      tick();
      ADD_I = 2'd3;
      #1;
      if (DAT_O[10:8] == 3'd0 && DAT_O[1]) break;
    end
    rd(2'd2, 32'd4, "t2_cnt");
    rd(2'd3, 32'hB, "t2_idle");

    // Clamping and flush clearing overflow.
    wr(2'd0, 32'd4);
    wr(2'd1, 32'd0);
    rd(2'd1, 32'd2, "t3_clamp0");
    wr(2'd0, 32'hC);
    rd(2'd3, 32'h3, "t3_flushed");
    wr(2'd1, 32'd1);
    rd(2'd1, 32'd2, "t3_clamp1");

    // Flush during WAIT abandons the interval.
    wr(2'd0, 32'd5);
    for (int i = 0; i < 20; i++) begin
      tick();
      ADD_I = 2'd3;
      #1;
      if (DAT_O[10:8] == 3'd4) break;
    end
    wr(2'd0, 32'hD);
    check("t4_halt_twe", TWE_O, 1);
    check("t4_halt_dat", TDAT_O, 0);
    rd(2'd3, 32'h603, "t4_halt_st");
    rd(2'd2, 32'd4, "t4_cnt");
    tick();
    TIRQ_I = 1;
    tick();
    rd(2'd3, 32'h3, "t4_idle");
    rd(2'd2, 32'd4, "t4_late");

    // Random traffic with occasional resets and spurious timer interrupts.
    noise_en = 1;
    for (int c = 0; c < 4000; c++) begin
      RST_I = ($urandom_range(0, 599) == 0);
      WE_I  = ($urandom_range(0, 5) == 0);
      ADD_I = 2'($urandom_range(0, 3));
      case (ADD_I)
        2'd0: DAT_I = ($urandom & 32'hFFFF_FFF0) |
                      {28'd0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0};
        2'd1: DAT_I = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 9);
        default: DAT_I = $urandom;
      endcase
      tick();
    end
    RST_I = 0;
    WE_I  = 0;
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
